// File: rtl/delay_pool_pkg.sv
// delay_pool_pkg: slot state encoding and delay clamp shared by the delay pool
package delay_pool_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} slot_state_e;
  function automatic int clamp_delay(input int d, input int m);
    return d > m ? m : d;
  endfunction
endpackage

// File: rtl/delay_pool_slot.sv
// delay_pool_slot: one in-flight slot with its down-counter, data and tag
module delay_pool_slot
  import delay_pool_pkg::*;
#(
  parameter int width       = 16,
  parameter int tag_width   = 4,
  parameter int delay_width = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   rel,
  input  logic [width-1:0]       data_in,
  input  logic [tag_width-1:0]   tag_in,
  input  logic [delay_width-1:0] cnt_in,
  output logic                   idle,
  output logic                   done,
  output logic [width-1:0]       data,
  output logic [tag_width-1:0]   tag
);
  slot_state_e state;
  logic [delay_width-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= '0;
      tag   <= '0;
    end else if (state == IDLE) begin
      if (load) begin
        state <= COUNT;
        cnt   <= cnt_in;
        data  <= data_in;
        tag   <= tag_in;
      end
    end else if (state == COUNT) begin
      if (cnt == '0) state <= DONE;
      else cnt <= cnt - 1'b1;
    end else if (rel) begin
      state <= IDLE;
    end
  end
  assign idle = state == IDLE;
  assign done = state == DONE;
endmodule

// File: rtl/delay_pool_model.sv
// delay_pool_model: pool of variable-latency slots completing out of order,
// with lowest-index allocation and lowest-index output priority
module delay_pool_model
  import delay_pool_pkg::*;
#(
  parameter int width       = 16,
  parameter int tag_width   = 4,
  parameter int n_slots     = 4,
  parameter int max_delay   = 7,
  parameter int delay_width = $clog2(max_delay + 1),
  parameter int cnt_width   = $clog2(n_slots + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld_in,
  output logic                   rdy_in,
  input  logic [width-1:0]       data_in,
  input  logic [tag_width-1:0]   tag_in,
  input  logic [delay_width-1:0] delay_in,
  output logic                   vld_out,
  input  logic                   rdy_out,
  output logic [width-1:0]       data_out,
  output logic [tag_width-1:0]   tag_out,
  output logic [cnt_width-1:0]   n_busy
);
  logic [n_slots-1:0]     idle, done, load, rel, free_sel, out_sel;
  logic [width-1:0]       s_data [n_slots];
  logic [tag_width-1:0]   s_tag  [n_slots];
  logic [delay_width-1:0] cnt_in;
  logic                   accept, fire;
  assign cnt_in  = delay_width'(clamp_delay(int'(delay_in), max_delay));
  assign rdy_in  = |idle;
  assign vld_out = |done;
  assign accept  = vld_in && rdy_in;
  assign fire    = vld_out && rdy_out;
  assign load    = accept ? free_sel : '0;
  assign rel     = fire ? out_sel : '0;
  // Both selects take the first match scanning upward from slot 0
  always_comb begin
    free_sel = '0;
    out_sel  = '0;
    data_out = '0;
    tag_out  = '0;
    for (int i = 0; i < n_slots; i++) begin
      if (idle[i] && free_sel == '0) free_sel[i] = 1'b1;
      if (done[i] && out_sel == '0) begin
        out_sel[i] = 1'b1;
        data_out   = s_data[i];
        tag_out    = s_tag[i];
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) n_busy <= '0;
    else if (accept && !fire) n_busy <= n_busy + 1'b1;
    else if (fire && !accept) n_busy <= n_busy - 1'b1;
  end
  for (genvar i = 0; i < n_slots; i++) begin : g_slot
    delay_pool_slot #(
      .width      (width),
      .tag_width  (tag_width),
      .delay_width(delay_width)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load   (load[i]),
      .rel    (rel[i]),
      .data_in(data_in),
      .tag_in (tag_in),
      .cnt_in (cnt_in),
      .idle   (idle[i]),
      .done   (done[i]),
      .data   (s_data[i]),
      .tag    (s_tag[i])
    );
  end
endmodule

// File: tb/tb_delay_pool_model.sv
// tb_delay_pool_model: directed and random checks of delay_pool_model against
// an item-level model that tracks each slot's completion time
module tb_delay_pool_model;
  import delay_pool_pkg::*;
  localparam int NS = 4, MD = 7, DW = 3;
  logic        clk = 0, rst = 0;
  logic        vld_in, rdy_in, vld_out, rdy_out;
  logic [15:0] data_in, data_out;
  logic [3:0]  tag_in, tag_out;
  logic [2:0]  delay_in, n_busy;
  logic        vld_c, rdy_c, vld_out_c, rdy_out_c;
  logic [2:0]  delay_c, n_busy_c;
  logic [15:0] data_out_c;
  logic [3:0]  tag_out_c;

  delay_pool_model dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_in), .data_in(data_in),
    .tag_in(tag_in), .delay_in(delay_in), .vld_out(vld_out), .rdy_out(rdy_out),
    .data_out(data_out), .tag_out(tag_out), .n_busy(n_busy)
  );
  delay_pool_model #(.max_delay(5)) dut_c (
    .clk(clk), .rst(rst), .vld_in(vld_c), .rdy_in(rdy_c), .data_in(data_in),
    .tag_in(tag_in), .delay_in(delay_c), .vld_out(vld_out_c), .rdy_out(rdy_out_c),
    .data_out(data_out_c), .tag_out(tag_out_c), .n_busy(n_busy_c)
  );

  always #5 clk = ~clk;

  // An item becomes visible once ecount (edges seen) reaches ready_at
  typedef struct {bit busy; int ready_at; logic [15:0] data; logic [3:0] tag;} item_t;
  item_t m [NS];
  int    ecount = 0, checks = 0, errors = 0;
  bit    dut_acc, dut_rel;
  int    rel_q[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sel = -1, busy = 0;
    bit free = 0;
    logic [15:0] ed = 0;
    logic [3:0]  et = 0;
    for (int i = 0; i < NS; i++) begin
      if (m[i].busy) busy++; else free = 1;
      if (sel < 0 && m[i].busy && ecount >= m[i].ready_at) sel = i;
    end
    if (sel >= 0) begin
      ed = m[sel].data;
      et = m[sel].tag;
    end
    chk("rdy_in", rdy_in, free);
    chk("vld_out", vld_out, sel >= 0);
    chk("data_out", data_out, ed);
    chk("tag_out", tag_out, et);
    chk("n_busy", n_busy, busy);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m[i].busy = 0;
  endtask

  task automatic step(input bit v, input logic [15:0] d, input logic [3:0] t, input int dl, input bit ro);
    int fi = -1, sel = -1;
    vld_in = v; data_in = d; tag_in = t; delay_in = DW'(dl); rdy_out = ro;
    for (int i = 0; i < NS; i++) begin
      if (fi < 0 && !m[i].busy) fi = i;
      if (sel < 0 && m[i].busy && ecount >= m[i].ready_at) sel = i;
    end
    dut_acc = v && rdy_in;
    dut_rel = vld_out && ro;
    if (dut_rel) rel_q.push_back(int'(tag_out));
    @(posedge clk);
    ecount++;
    if (sel >= 0 && ro) m[sel].busy = 0;
    if (v && fi >= 0) begin
      m[fi].busy = 1;
      m[fi].ready_at = ecount + clamp_delay(dl, MD) + 1;
      m[fi].data = d;
      m[fi].tag = t;
    end
    #1 check_outputs();
  endtask

  initial begin
    int lat, acc_k, rel_k;
    int exp_o[3] = '{1, 2, 0};
    vld_in = 0; data_in = 0; tag_in = 0; delay_in = 0; rdy_out = 0;
    vld_c = 0; delay_c = 0; rdy_out_c = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs();
    chk("c_vld_rst", vld_out_c, 0);
    chk("c_rdy_rst", rdy_c, 1);
    rst = 1;

    // single item, delay 5
    step(1, 16'h00AB, 3, 5, 1);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 0, 1);
      if (lat < 0 && vld_out) begin
        lat = k;
        chk("single_data", data_out, 16'h00AB);
        chk("single_tag", tag_out, 3);
      end
    end
    chk("single_lat", lat, 6);
    chk("single_busy_end", n_busy, 0);

    // out-of-order completion
    rel_q.delete();
    step(1, 16'h0010, 0, 6, 1);
    step(1, 16'h0011, 1, 0, 1);
    step(1, 16'h0012, 2, 3, 1);
    repeat (12) step(0, 0, 0, 0, 1);
    chk("ooo_count", rel_q.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("ooo_%0d", i), i < rel_q.size() ? rel_q[i] : -1, exp_o[i]);

    // full pool: fifth item waits for the first release
    for (int i = 0; i < 4; i++) step(1, 16'h0100 + 16'(i), 4'(4 + i), 7, 1);
    chk("full_rdy", rdy_in, 0);
    acc_k = -100; rel_k = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1, 16'h0555, 9, 7, 1);
      if (dut_rel && rel_k < 0) rel_k = k;
      if (dut_acc) begin
        acc_k = k;
        break;
      end
    end
    chk("full_5th", acc_k - rel_k, 1);
    repeat (20) step(0, 0, 0, 0, 1);

    // simultaneous completion under backpressure
    rel_q.delete();
    step(1, 16'h00A1, 10, 3, 0);
    step(1, 16'h00B2, 11, 2, 0);
    repeat (10) step(0, 0, 0, 0, 0);
    chk("coll_busy", n_busy, 2);
    chk("coll_vld", vld_out, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    chk("coll_count", rel_q.size(), 2);
    chk("coll_first", rel_q.size() > 0 ? rel_q[0] : -1, 10);
    chk("coll_second", rel_q.size() > 1 ? rel_q[1] : -1, 11);

    // clamp: max_delay 5 instance, delay 7 behaves as 5
    vld_in = 0; data_in = 16'h0C1A; tag_in = 5; vld_c = 1; delay_c = 7;
    @(posedge clk);
    #1 vld_c = 0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && vld_out_c) begin
        lat = k;
        chk("clamp_data", data_out_c, 16'h0C1A);
        chk("clamp_tag", tag_out_c, 5);
      end
    end
    chk("clamp_lat", lat, 6);

    // asynchronous reset with three items in flight
    rel_q.delete();
    step(1, 16'h0001, 1, 5, 1);
    step(1, 16'h0002, 2, 4, 1);
    step(1, 16'h0003, 3, 6, 1);
    #1 rst = 0;
    #1;
    chk("rst_vld", vld_out, 0);
    chk("rst_rdy", rdy_in, 1);
    chk("rst_busy", n_busy, 0);
    chk("rst_data", data_out, 0);
    chk("rst_tag", tag_out, 0);
    model_reset();
    #1 rst = 1;
    repeat (12) step(0, 0, 0, 0, 1);
    chk("rst_no_stale", rel_q.size(), 0);

    // random traffic
    repeat (400)
      step(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0);
    repeat (20) step(0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/delay_pool_model.md
# delay_pool_model

Synthesizable, parametrised variable-latency processing model with `n_slots` independent in-flight slots. Each accepted item carries a data word, an order tag and a per-item delay, and emerges after that delay, so items complete out of order. The block replaces the single-outstanding, simulation-only delay model as the stimulus source for reorder blocks such as put-in-order. Adds input backpressure, output backpressure and multiple outstanding items.

## Interface
- `width`, 16, data width
- `tag_width`, 4, order tag width, carried unmodified
- `n_slots`, 4, maximum items in flight (≥1)
- `max_delay`, 7, largest honoured delay value
- `delay_width`, `$clog2(max_delay+1)`, width of `delay_in`
- `cnt_width`, `$clog2(n_slots+1)`, width of `n_busy`

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `vld_in` in 1: input item valid.
- `rdy_in` out 1: a free slot exists; an item is accepted on an edge with `vld_in && rdy_in`.
- `data_in` in `width`: item data.
- `tag_in` in `tag_width`: item tag.
- `delay_in` in `delay_width`: item delay in cycles; values above `max_delay` clamp to `max_delay`.
- `vld_out` out 1: completed item presented.
- `rdy_out` in 1: consumer ready; an item is released on an edge with `vld_out && rdy_out`.
- `data_out` out `width`: completed item data.
- `tag_out` out `tag_width`: completed item tag.
- `n_busy` out `cnt_width`: number of non-IDLE slots.

## Operation
- Per-slot states are IDLE, COUNT and DONE. Each slot holds data, tag and a down-counter `cnt`.
- Allocation:
  - On an accept edge, the lowest-index IDLE slot loads data, tag and the clamped delay into `cnt`, and goes to COUNT.
  - At most one accept per cycle.
- COUNT:
  - Each edge: if `cnt==0`, go to DONE; else `cnt <= cnt-1`.
- DONE:
  - The slot waits until selected.
  - The output selects the lowest-index DONE slot. `vld_out` = any slot in DONE. `data_out`/`tag_out` are muxed from the selected slot, and are zero when no slot is in DONE.
  - On a release edge, the selected slot goes to IDLE.
  - Other DONE slots hold indefinitely; no data is lost under backpressure.
- `rdy_in` = any slot IDLE, computed from current state only.
  - A slot freed on edge T is allocatable from edge T+1, not on edge T.
- `n_busy` is a registered count: +1 on accept, −1 on release, unchanged when both occur on the same edge.
- No combinational path exists from any input to any output.

## Timing
- Reset values: all slots IDLE, `cnt`/data/tag 0, `vld_out`=0, `data_out`=0, `tag_out`=0, `n_busy`=0, `rdy_in`=1 (with `n_slots`≥1).
- Reset asserted mid-operation discards all in-flight items immediately, asynchronously.
- Latency:
  - Item accepted on edge T with delay d shows `vld_out` high in the cycle after edge T+d+1, provided no lower-index DONE slot is waiting.
  - Delay 0 therefore means data is visible one cycle after acceptance.
- Full pool: `rdy_in`=0. `vld_in` is ignored; the source must hold the item.
- Simultaneous completion: the lower slot index wins; the others are delayed one cycle per release ahead of them.
- Accept and release on the same edge are both legal and independent.

## Structure
- Package `delay_pool_pkg` holds the slot-state enum typedef (`IDLE`, `COUNT`, `DONE`) and a clamp function for the delay.
- Sub-module `delay_pool_slot` holds one slot's state machine, counter, data and tag registers, with load/release inputs and a done output. The top level contains allocation priority, output priority mux and the `n_busy` counter.
- Priority encoders are lowest-index-first loops in the top level.

## Test plan
- Single item: data 0x00AB, tag 3, delay 5 with `rdy_out`=1 → `vld_out` in the cycle after edge T+6, `data_out`=0x00AB, `tag_out`=3, `n_busy` 1→0.
- Out-of-order: tags 0,1,2 accepted back-to-back with delays 6,0,3 → outputs emerge in tag order 1,2,0.
- Full pool: 5 items, delay 7, `n_slots`=4 → `rdy_in`=0 after the 4th accept. The 5th item is accepted only on the edge after the first release.
- Collision/backpressure:
  - Two items complete on the same edge, `rdy_out`=0 for 10 cycles → both held and `n_busy`=2.
  - Then the lower-slot item is released first, the other one cycle later.
- Clamp and reset:
  - With `max_delay`=5, `delay_in`=7 → latency 6.
  - `rst` pulled low with 3 items in flight → all outputs return to reset values immediately and no stale item appears after release.
